// File: rtl/alu_pipe_checker.sv
// In-order ALU result checker: predicts each issued op, queues it, compares DUT results at the head.
// Optional watchdog enabled by defining ALU_CHK_TIMEOUT_EN.
module alu_pipe_checker #(
  parameter int NBIT      = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 64,
  parameter bit REPORT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [NBIT-1:0]        in_a,
  input  logic [NBIT-1:0]        in_b,
  input  logic [3:0]             in_op,
  input  logic                   out_valid,
  input  logic [NBIT-1:0]        out_res,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [3:0]             first_fail_op,
  output logic [NBIT-1:0]        first_fail_exp,
  output logic [NBIT-1:0]        first_fail_got,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Operands ride along only so a failure report can show them.
  typedef struct packed {
    logic [3:0]      op;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic [NBIT-1:0] exp;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NBIT-1:0] pred;
  logic            push, pop, full, empty, wr_en, match;

  always_comb begin
    pred = '0;
    case (in_op)
      4'd0: pred = in_a + in_b;
      4'd1: pred = in_a - in_b;
      4'd2: pred = in_a & in_b;
      4'd3: pred = in_a | in_b;
      4'd4: pred = in_a ^ in_b;
      4'd5: pred = {{(NBIT-1){1'b0}}, in_a <= in_b};
      4'd6: pred = {{(NBIT-1){1'b0}}, in_a >= in_b};
      4'd7: pred = {{(NBIT-1){1'b0}}, in_a != in_b};
      // Shift amounts >= NBIT already yield zero under SV shift semantics.
      4'd8: pred = in_a >> in_b;
      4'd9: pred = in_a << in_b;
      default: pred = '0;
    endcase
  end

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign push  = in_valid;
  assign pop   = out_valid && !empty;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];
  assign match = (head.exp == out_res);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b, exp: pred};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      level <= level + 1'b1;
      else if (pop && !wr_en) level <= level - 1'b1;
      if (push && full && !pop) overflow  <= 1'b1;
      if (out_valid && empty)   underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_op  <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      mismatch <= pop && !match;
      if (pop && match && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if (pop && !match) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        // fail_cnt never returns to zero once a failure is seen, so it doubles as the capture lock.
        if (fail_cnt == '0) begin
          first_fail_op  <= head.op;
          first_fail_exp <= head.exp;
          first_fail_got <= out_res;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (REPORT_EN && !rst && pop && !match)
      $error("alu_pipe_checker: op=%0d a=%h b=%h exp=%h got=%h",
             head.op, head.a, head.b, head.exp, out_res);
  end

`ifdef ALU_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_hit;

  assign wd_hit = !pop && !empty && (wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (pop || empty)              wd_cnt <= '0;
      else if (wd_cnt != TW'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) timeout <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (REPORT_EN && !rst && wd_hit && !timeout)
      $error("alu_pipe_checker: no result for %0d cycles, level=%0d", TIMEOUT, level);
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe_checker.sv
// Directed bench for alu_pipe_checker at NBIT=8, DEPTH=4, TIMEOUT=10.
module tb_alu_pipe_checker;
  localparam int NBIT = 8, DEPTH = 4, CNT_W = 16, TIMEOUT = 10, NV = 11;

  logic            clk = 1'b0, rst = 1'b1;
  logic            in_valid = 1'b0, out_valid = 1'b0;
  logic [NBIT-1:0] in_a = '0, in_b = '0, out_res = '0;
  logic [3:0]      in_op = '0;
  logic            mismatch, overflow, underflow, timeout;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [3:0]      first_fail_op;
  logic [NBIT-1:0] first_fail_exp, first_fail_got;
  logic [$clog2(DEPTH):0] level;

  int checks = 0, failures = 0;

  logic [3:0]      v_op  [NV];
  logic [NBIT-1:0] v_a   [NV];
  logic [NBIT-1:0] v_b   [NV];
  logic [NBIT-1:0] v_exp [NV];

  alu_pipe_checker #(.NBIT(NBIT), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .REPORT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_res(out_res), .mismatch(mismatch), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .first_fail_op(first_fail_op), .first_fail_exp(first_fail_exp),
    .first_fail_got(first_fail_got), .overflow(overflow), .underflow(underflow),
    .timeout(timeout), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [3:0] op, input logic [NBIT-1:0] a,
                       input logic [NBIT-1:0] b, input logic ov, input logic [NBIT-1:0] res);
    in_valid = iv; in_op = op; in_a = a; in_b = b; out_valid = ov; out_res = res;
  endtask

  initial begin
    v_op[0]  = 4'd2;  v_a[0]  = 8'hF0; v_b[0]  = 8'h3C; v_exp[0]  = 8'h30;
    v_op[1]  = 4'd3;  v_a[1]  = 8'hF0; v_b[1]  = 8'h0F; v_exp[1]  = 8'hFF;
    v_op[2]  = 4'd4;  v_a[2]  = 8'hAA; v_b[2]  = 8'hFF; v_exp[2]  = 8'h55;
    v_op[3]  = 4'd5;  v_a[3]  = 8'h80; v_b[3]  = 8'h7F; v_exp[3]  = 8'h00;
    v_op[4]  = 4'd5;  v_a[4]  = 8'h05; v_b[4]  = 8'h05; v_exp[4]  = 8'h01;
    v_op[5]  = 4'd6;  v_a[5]  = 8'h01; v_b[5]  = 8'h80; v_exp[5]  = 8'h00;
    v_op[6]  = 4'd7;  v_a[6]  = 8'h03; v_b[6]  = 8'h03; v_exp[6]  = 8'h00;
    v_op[7]  = 4'd8;  v_a[7]  = 8'h80; v_b[7]  = 8'h07; v_exp[7]  = 8'h01;
    v_op[8]  = 4'd8;  v_a[8]  = 8'h80; v_b[8]  = 8'h08; v_exp[8]  = 8'h00;
    v_op[9]  = 4'd12; v_a[9]  = 8'h12; v_b[9]  = 8'h34; v_exp[9]  = 8'h00;
    v_op[10] = 4'd1;  v_a[10] = 8'h10; v_b[10] = 8'h20; v_exp[10] = 8'hF0;

    // reset state
    tick(); tick();
    chk("rst_pass", pass_cnt, 0);   chk("rst_fail", fail_cnt, 0);
    chk("rst_level", level, 0);     chk("rst_mismatch", mismatch, 0);
    chk("rst_ovf", overflow, 0);    chk("rst_udf", underflow, 0);
    chk("rst_tmo", timeout, 0);
    rst = 1'b0;

    // add/sub wrap, latency 3
    drive(1, 4'd0, 8'h7F, 8'h01, 0, 0); tick();
    chk("lat_level1", level, 1);
    drive(1, 4'd1, 8'h00, 8'h01, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);            tick();
    drive(0, 0, 0, 0, 1, 8'h80);        tick();
    chk("lat_mm0", mismatch, 0);
    drive(0, 0, 0, 0, 1, 8'hFF);        tick();
    chk("lat_mm1", mismatch, 0);
    drive(0, 0, 0, 0, 0, 0);            tick();
    chk("lat_pass", pass_cnt, 2); chk("lat_fail", fail_cnt, 0); chk("lat_level", level, 0);

    // back-to-back op table, latency 1
    drive(1, v_op[0], v_a[0], v_b[0], 0, 0); tick();
    for (int i = 1; i < NV; i++) begin
      drive(1, v_op[i], v_a[i], v_b[i], 1, v_exp[i-1]); tick();
      chk($sformatf("vec%0d_mm", i-1), mismatch, 0);
    end
    drive(0, 0, 0, 0, 1, v_exp[NV-1]); tick();
    chk("vec_last_mm", mismatch, 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("vec_pass", pass_cnt, 2 + NV); chk("vec_fail", fail_cnt, 0);

    // corrupted sll result
    drive(1, 4'd9, 8'h01, 8'h09, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 8'h02);        tick();
    chk("bad_mm", mismatch, 1);   chk("bad_fail", fail_cnt, 1);
    chk("bad_op", first_fail_op, 9);
    chk("bad_exp", first_fail_exp, 8'h00); chk("bad_got", first_fail_got, 8'h02);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("bad_mm_drop", mismatch, 0);
    drive(1, 4'd0, 8'h01, 8'h01, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 8'h05);        tick();
    chk("bad2_fail", fail_cnt, 2); chk("bad2_op", first_fail_op, 9);
    chk("bad2_exp", first_fail_exp, 8'h00); chk("bad2_got", first_fail_got, 8'h02);
    chk("bad2_pass", pass_cnt, 2 + NV);

    // overflow: five pushes into four slots, then push+pop while full
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'd0, 8'(i), 8'h00, 0, 0); tick();
    end
    chk("ovf_level", level, 4); chk("ovf_flag", overflow, 1);
    drive(1, 4'd0, 8'h05, 8'h00, 1, 8'h00); tick();
    chk("ovf_pp_level", level, 4); chk("ovf_pp_mm", mismatch, 0);
    drive(0, 0, 0, 0, 1, 8'h01); tick();
    drive(0, 0, 0, 0, 1, 8'h02); tick();
    drive(0, 0, 0, 0, 1, 8'h03); tick();
    drive(0, 0, 0, 0, 1, 8'h05); tick();
    chk("ovf_drain_mm", mismatch, 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("ovf_pass", pass_cnt, 2 + NV + 5); chk("ovf_level0", level, 0);
    chk("ovf_udf", underflow, 0);

    // underflow on empty FIFO
    drive(0, 0, 0, 0, 1, 8'h00); tick();
    drive(0, 0, 0, 0, 0, 0);     tick();
    chk("udf_flag", underflow, 1);
    chk("udf_pass", pass_cnt, 2 + NV + 5); chk("udf_fail", fail_cnt, 2);

    // asynchronous reset with three outstanding ops
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd0, 8'h11, 8'h22, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_level", level, 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_level", level, 0);   chk("arst_pass", pass_cnt, 0);
    chk("arst_fail", fail_cnt, 0); chk("arst_ovf", overflow, 0);
    chk("arst_udf", underflow, 0); chk("arst_ffop", first_fail_op, 0);
    chk("arst_ffgot", first_fail_got, 0);
    tick(); rst = 1'b0; tick();
    drive(0, 0, 0, 0, 1, 8'h33); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_udf", underflow, 1); chk("post_rst_pass", pass_cnt, 0);

    // watchdog: one op, result withheld
    drive(1, 4'd0, 8'h01, 8'h02, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_early", timeout, 0);
    for (int i = 0; i < 7; i++) tick();
`ifdef ALU_CHK_TIMEOUT_EN
    chk("tmo_late", timeout, 1);
`else
    chk("tmo_late", timeout, 0);
`endif
    drive(0, 0, 0, 0, 1, 8'h03); tick();
    drive(0, 0, 0, 0, 0, 0);     tick();
    chk("tmo_pass", pass_cnt, 1); chk("tmo_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
